// File: rtl/ddr_frame_wr_scheduler_pkg.sv
// ddr_frame_wr_scheduler_pkg
// Shared definitions for the DDR frame write scheduler:
//   - scheduler state encoding
//   - 4 KB page constant (AXI bursts must not cross it)
//   - helpers deriving bytes-per-beat and the beat shift from the bus width
package ddr_frame_wr_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_WAIT_DATA,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_DONE
    } schedState_e;

    localparam int unsigned FOUR_KB = 4096;

    function automatic int bytesPerBeat(input int dataWidth);
        return dataWidth / 8;
    endfunction

    function automatic int beatShift(input int dataWidth);
        return $clog2(dataWidth / 8);
    endfunction

endpackage

// File: rtl/ddr_frame_wr_scheduler_burst_sizer.sv
// ddr_burst_sizer
// Combinational burst length chooser: the smallest of the beats still owed on
// the current line, the maximum burst length, and the beats left before the
// next 4 KB page boundary.
// Ports:
//   remBeats_i  beats remaining on the current line
//   addrLow_i   low 12 bits of the burst start byte address (beat aligned)
//   beats_o     beats to issue in the next burst (1..MAX_BURST when remBeats_i != 0)
module ddr_burst_sizer
    import ddr_frame_wr_scheduler_pkg::*;
#(
    parameter int MAX_BURST = 64,
    parameter int BSH       = 5
) (
    input  logic [15:0] remBeats_i,
    input  logic [11:0] addrLow_i,
    output logic [8:0]  beats_o
);

    logic [12:0] pageRoom;
    logic [12:0] roomBeats;
    logic [8:0]  capped;

    // Room to the page end is 1..4096 bytes, hence 13 bits. Once the line
    // remainder has been clamped to MAX_BURST (<= 256) everything fits in 9 bits.
    always_comb begin
        pageRoom  = 13'(FOUR_KB) - {1'b0, addrLow_i};
        roomBeats = pageRoom >> BSH;
        capped    = (remBeats_i > 16'(MAX_BURST)) ? 9'(MAX_BURST) : remBeats_i[8:0];
        beats_o   = ({4'd0, capped} > roomBeats) ? roomBeats[8:0] : capped;
    end

endmodule

// File: rtl/ddr_frame_wr_scheduler.sv
// ddr_frame_wr_scheduler
// Writes one video frame per accepted frame_start into a ring of NUM_BUF DDR
// frame buffers. Each line is cut into AXI bursts of at most MAX_BURST beats
// that never cross a 4 KB page. A burst is only issued once the line FIFO holds
// all of its beats. The finished buffer index is reported to the read side.
// Ports:
//   clk, rst                      clock, async active-high reset
//   frame_start                   pulse: begin writing the next buffer
//   cfg_base_addr/cfg_buf_stride  ring base and buffer spacing (bytes)
//   cfg_line_stride               line spacing (bytes)
//   cfg_line_beats/cfg_line_count frame geometry
//   fifo_rd_count                 beats available in the line FIFO
//   burst_start/burst_addr/burst_len  burst request to the write controller
//   burst_done                    last beat of the issued burst accepted
//   busy                          frame in progress
//   frame_done/done_buf_idx       frame completion pulse and buffer index
//   frame_drop                    frame_start arrived while busy and was ignored
module ddr_frame_wr_scheduler
    import ddr_frame_wr_scheduler_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 256,
    parameter int MAX_BURST      = 64,
    parameter int NUM_BUF        = 3,
    parameter int FIFO_CNT_W     = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic [31:0]           cfg_base_addr,
    input  logic [31:0]           cfg_buf_stride,
    input  logic [31:0]           cfg_line_stride,
    input  logic [15:0]           cfg_line_beats,
    input  logic [15:0]           cfg_line_count,
    input  logic [FIFO_CNT_W-1:0] fifo_rd_count,
    output logic                  burst_start,
    output logic [31:0]           burst_addr,
    output logic [7:0]            burst_len,
    input  logic                  burst_done,
    output logic                  busy,
    output logic                  frame_done,
    output logic [1:0]            done_buf_idx,
    output logic                  frame_drop
);

    localparam int BSH = beatShift(AXI_DATA_WIDTH);

    schedState_e state_q;
    logic [1:0]  wrIdx_q;
    logic [31:0] lineStride_q;
    logic [15:0] lineBeats_q;
    logic [15:0] lineCount_q;
    logic [31:0] lineAddr_q;
    logic [31:0] curAddr_q;
    logic [15:0] rem_q;
    logic [15:0] line_q;
    logic [8:0]  beats_q;

    logic        burstStart_q;
    logic [31:0] burstAddr_q;
    logic [7:0]  burstLen_q;
    logic        busy_q;
    logic        frameDone_q;
    logic [1:0]  doneBufIdx_q;
    logic        frameDrop_q;

    logic [1:0]  wrIdx_d;
    logic [31:0] bufBase_d;
    logic [31:0] curAddrStep_d;
    logic [31:0] nextLineAddr_d;
    logic [15:0] remAfter_d;
    logic        dataReady;
    logic [8:0]  sizerBeats;

    ddr_burst_sizer #(
        .MAX_BURST (MAX_BURST),
        .BSH       (BSH)
    ) uSizer (
        .remBeats_i (rem_q),
        .addrLow_i  (curAddr_q[11:0]),
        .beats_o    (sizerBeats)
    );

    // Next-state helpers. The buffer base is built by shift-and-add from the
    // two index bits (NUM_BUF <= 4), so no multiplier is needed.
    always_comb begin
        wrIdx_d        = (wrIdx_q == 2'(NUM_BUF - 1)) ? 2'd0 : wrIdx_q + 2'd1;
        bufBase_d      = cfg_base_addr
                       + (wrIdx_d[0] ? cfg_buf_stride : 32'd0)
                       + (wrIdx_d[1] ? {cfg_buf_stride[30:0], 1'b0} : 32'd0);
        curAddrStep_d  = curAddr_q + ({23'd0, beats_q} << BSH);
        nextLineAddr_d = lineAddr_q + lineStride_q;
        remAfter_d     = rem_q - {7'd0, beats_q};
        dataReady      = (32'(fifo_rd_count) >= 32'(beats_q));
    end

    // Scheduler FSM with registered outputs. Pulse outputs default low every
    // cycle, so burst_start and frame_done appear for exactly one cycle in the
    // cycle following ISSUE and DONE respectively.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wrIdx_q      <= 2'(NUM_BUF - 1);
            lineStride_q <= '0;
            lineBeats_q  <= '0;
            lineCount_q  <= '0;
            lineAddr_q   <= '0;
            curAddr_q    <= '0;
            rem_q        <= '0;
            line_q       <= '0;
            beats_q      <= '0;
            burstStart_q <= 1'b0;
            burstAddr_q  <= '0;
            burstLen_q   <= '0;
            busy_q       <= 1'b0;
            frameDone_q  <= 1'b0;
            doneBufIdx_q <= '0;
            frameDrop_q  <= 1'b0;
        end else begin
            burstStart_q <= 1'b0;
            frameDone_q  <= 1'b0;
            frameDrop_q  <= frame_start && (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        lineStride_q <= cfg_line_stride;
                        lineBeats_q  <= cfg_line_beats;
                        lineCount_q  <= cfg_line_count;
                        wrIdx_q      <= wrIdx_d;
                        lineAddr_q   <= bufBase_d;
                        curAddr_q    <= bufBase_d;
                        rem_q        <= cfg_line_beats;
                        line_q       <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= (cfg_line_beats == 16'd0 || cfg_line_count == 16'd0)
                                        ? ST_DONE : ST_CALC;
                    end
                end
                ST_CALC: begin
                    beats_q <= sizerBeats;
                    state_q <= ST_WAIT_DATA;
                end
                ST_WAIT_DATA: begin
                    if (dataReady) begin
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    burstStart_q <= 1'b1;
                    burstAddr_q  <= curAddr_q;
                    burstLen_q   <= 8'(beats_q - 9'd1);
                    state_q      <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (burst_done) begin
                        if (remAfter_d != 16'd0) begin
                            curAddr_q <= curAddrStep_d;
                            rem_q     <= remAfter_d;
                            state_q   <= ST_CALC;
                        end else if (line_q + 16'd1 == lineCount_q) begin
                            curAddr_q <= curAddrStep_d;
                            rem_q     <= remAfter_d;
                            state_q   <= ST_DONE;
                        end else begin
                            lineAddr_q <= nextLineAddr_d;
                            curAddr_q  <= nextLineAddr_d;
                            rem_q      <= lineBeats_q;
                            line_q     <= line_q + 16'd1;
                            state_q    <= ST_CALC;
                        end
                    end
                end
                ST_DONE: begin
                    frameDone_q  <= 1'b1;
                    doneBufIdx_q <= wrIdx_q;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign burst_start  = burstStart_q;
    assign burst_addr   = burstAddr_q;
    assign burst_len    = burstLen_q;
    assign busy         = busy_q;
    assign frame_done   = frameDone_q;
    assign done_buf_idx = doneBufIdx_q;
    assign frame_drop   = frameDrop_q;

endmodule

// File: tb/tb_ddr_frame_wr_scheduler.sv
// tb_ddr_frame_wr_scheduler
// Scoreboard bench: each accepted frame_start expands, through a reference model
// working in plain arithmetic, into the list of bursts and the completion index
// the scheduler must produce. A monitor pops and compares those whenever the
// DUT pulses burst_start or frame_done; a responder answers every burst with a
// randomly delayed burst_done.
module tb_ddr_frame_wr_scheduler;

    localparam int NUM_BUF   = 3;
    localparam int BYTES     = 32;
    localparam int MAX_BURST = 64;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } burst_t;

    logic        clk;
    logic        rst;
    logic        frame_start;
    logic [31:0] cfg_base_addr;
    logic [31:0] cfg_buf_stride;
    logic [31:0] cfg_line_stride;
    logic [15:0] cfg_line_beats;
    logic [15:0] cfg_line_count;
    logic [9:0]  fifo_rd_count;
    logic        burst_start;
    logic [31:0] burst_addr;
    logic [7:0]  burst_len;
    logic        burst_done;
    logic        busy;
    logic        frame_done;
    logic [1:0]  done_buf_idx;
    logic        frame_drop;

    logic        respEn;
    logic        respDone;
    logic        manualDone;
    logic        randFifo;

    burst_t      expQ[$];
    int          expFrameQ[$];
    burst_t      monBurst;
    int          monIdx;
    int          modelIdx;
    int          testsRun;
    int          testsFailed;
    int          burstsSeen;

    assign burst_done = respDone | manualDone;

    ddr_frame_wr_scheduler #(
        .AXI_DATA_WIDTH (256),
        .MAX_BURST      (MAX_BURST),
        .NUM_BUF        (NUM_BUF),
        .FIFO_CNT_W     (10)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .frame_start     (frame_start),
        .cfg_base_addr   (cfg_base_addr),
        .cfg_buf_stride  (cfg_buf_stride),
        .cfg_line_stride (cfg_line_stride),
        .cfg_line_beats  (cfg_line_beats),
        .cfg_line_count  (cfg_line_count),
        .fifo_rd_count   (fifo_rd_count),
        .burst_start     (burst_start),
        .burst_addr      (burst_addr),
        .burst_len       (burst_len),
        .burst_done      (burst_done),
        .busy            (busy),
        .frame_done      (frame_done),
        .done_buf_idx    (done_buf_idx),
        .frame_drop      (frame_drop)
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case some wait is never satisfied
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached, tests run %0d", testsRun);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference model: buffer base from index*stride, each line walked in bursts
    // limited by the line remainder, MAX_BURST and the room left in the 4 KB page
    task automatic modelFrame(input logic [31:0] base, input logic [31:0] bufStride,
                              input logic [31:0] lineStride, input int lineBeats, input int lineCount);
        logic [31:0] addr;
        int          rem;
        int          room;
        int          b;
        burst_t      e;
        modelIdx = (modelIdx + 1) % NUM_BUF;
        if (lineBeats != 0 && lineCount != 0) begin
            for (int l = 0; l < lineCount; l++) begin
                addr = base + 32'(modelIdx) * bufStride + 32'(l) * lineStride;
                rem  = lineBeats;
                while (rem > 0) begin
                    room = (4096 - int'(addr[11:0])) / BYTES;
                    b    = rem;
                    if (b > MAX_BURST) b = MAX_BURST;
                    if (b > room) b = room;
                    e.addr = addr;
                    e.len  = 8'(b - 1);
                    expQ.push_back(e);
                    addr = addr + 32'(b * BYTES);
                    rem  = rem - b;
                end
            end
        end
        expFrameQ.push_back(modelIdx);
    endtask

    // Program a frame, record its expected bursts and pulse frame_start for one cycle
    task automatic applyStimulus(input logic [31:0] base, input logic [31:0] bufStride,
                                 input logic [31:0] lineStride, input int lineBeats, input int lineCount);
        cfg_base_addr   = base;
        cfg_buf_stride  = bufStride;
        cfg_line_stride = lineStride;
        cfg_line_beats  = 16'(lineBeats);
        cfg_line_count  = 16'(lineCount);
        modelFrame(base, bufStride, lineStride, lineBeats, lineCount);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // Run until the frame is finished and the scoreboard is drained; optionally
    // jitter the FIFO level and inject frame_start pulses that must be dropped
    task automatic waitIdle(input string name);
        int cyc;
        cyc = 0;
        while ((busy || expQ.size() != 0 || expFrameQ.size() != 0) && cyc < 4000) begin
            if (randFifo) fifo_rd_count = 10'($urandom_range(0, 300));
            if (randFifo && busy && $urandom_range(0, 29) == 0) begin
                frame_start = 1'b1;
                @(negedge clk);
                cyc++;
                checkOutput("frame_drop on busy start", 32'(frame_drop), 32'd1);
                frame_start = 1'b0;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        testsRun++;
        if (cyc >= 4000) begin
            testsFailed++;
            $display("[TB] FAIL %s timeout: busy=%0d pending bursts=%0d pending frames=%0d, required idle and drained",
                     name, busy, expQ.size(), expFrameQ.size());
        end
    endtask

    // Monitor: compare every burst request and frame completion with the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (burst_start) begin
                burstsSeen++;
                if (expQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected burst: got addr 0x%08h len %0d, required none", burst_addr, burst_len);
                end else begin
                    monBurst = expQ.pop_front();
                    checkOutput("burst_addr", burst_addr, monBurst.addr);
                    checkOutput("burst_len", 32'(burst_len), 32'(monBurst.len));
                end
            end
            if (frame_done) begin
                if (expFrameQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected frame_done: got idx %0d, required none", done_buf_idx);
                end else begin
                    monIdx = expFrameQ.pop_front();
                    checkOutput("done_buf_idx", 32'(done_buf_idx), 32'(monIdx));
                end
            end
        end
    end

    // Burst write controller stand-in: acknowledge each burst after 0..3 cycles
    initial begin
        respDone = 1'b0;
        forever begin
            @(negedge clk);
            if (respEn && burst_start && !rst) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                respDone = 1'b1;
                @(negedge clk);
                respDone = 1'b0;
            end
        end
    end

    // Directed scenarios followed by randomized frames
    initial begin
        int lat;
        int seenBefore;
        int cyc;

        testsRun        = 0;
        testsFailed     = 0;
        burstsSeen      = 0;
        modelIdx        = NUM_BUF - 1;
        rst             = 1'b1;
        frame_start     = 1'b0;
        cfg_base_addr   = '0;
        cfg_buf_stride  = '0;
        cfg_line_stride = '0;
        cfg_line_beats  = '0;
        cfg_line_count  = '0;
        fifo_rd_count   = '0;
        manualDone      = 1'b0;
        respEn          = 1'b1;
        randFifo        = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset burst_start", 32'(burst_start), 32'd0);
        checkOutput("reset burst_addr", burst_addr, 32'd0);
        checkOutput("reset burst_len", 32'(burst_len), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset frame_done", 32'(frame_done), 32'd0);
        checkOutput("reset done_buf_idx", 32'(done_buf_idx), 32'd0);
        checkOutput("reset frame_drop", 32'(frame_drop), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Two lines of 16 beats, buffer 0, with start-to-burst latency
        fifo_rd_count = 10'd100;
        applyStimulus(32'h0000_1000, 32'h0010_0000, 32'h0000_0800, 16, 2);
        checkOutput("busy after start", 32'(busy), 32'd1);
        lat = 0;
        while (!burst_start && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("start to burst latency", 32'(lat), 32'd3);
        waitIdle("two-line frame");

        // 4 KB split and MAX_BURST split
        applyStimulus(32'h0000_0FC0, 32'h0, 32'h0000_0800, 8, 1);
        waitIdle("4KB split");
        applyStimulus(32'h0000_0000, 32'h0, 32'h0000_2000, 150, 1);
        waitIdle("long line");

        // Empty geometries go straight to completion
        applyStimulus(32'h0000_3000, 32'h0, 32'h0000_0800, 8, 0);
        waitIdle("zero lines");
        applyStimulus(32'h0000_3000, 32'h0, 32'h0000_0800, 0, 3);
        waitIdle("zero beats");

        // FIFO too shallow: hold off, then check a dropped start mid-frame
        fifo_rd_count = 10'd10;
        applyStimulus(32'h0000_2000, 32'h0, 32'h0000_0800, 16, 1);
        seenBefore = burstsSeen;
        repeat (20) @(negedge clk);
        checkOutput("no burst while FIFO short", 32'(burstsSeen - seenBefore), 32'd0);
        checkOutput("busy while stalled", 32'(busy), 32'd1);
        frame_start = 1'b1;
        @(negedge clk);
        checkOutput("frame_drop pulse", 32'(frame_drop), 32'd1);
        frame_start = 1'b0;
        @(negedge clk);
        checkOutput("frame_drop one cycle", 32'(frame_drop), 32'd0);
        fifo_rd_count = 10'd16;
        waitIdle("FIFO stall");

        // Ring rotation over four frames
        fifo_rd_count = 10'd1023;
        for (int f = 0; f < 4; f++) begin
            applyStimulus(32'h0, 32'h0010_0000, 32'h0000_0800, 4, 1);
            waitIdle("ring rotation");
        end

        // Reset while a burst is outstanding
        respEn = 1'b0;
        applyStimulus(32'h0, 32'h0010_0000, 32'h0000_0800, 32, 2);
        cyc = 0;
        while (!burst_start && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("burst before reset", 32'(burst_start), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("mid-frame reset busy", 32'(busy), 32'd0);
        checkOutput("mid-frame reset burst_addr", burst_addr, 32'd0);
        checkOutput("mid-frame reset burst_len", 32'(burst_len), 32'd0);
        checkOutput("mid-frame reset done_buf_idx", 32'(done_buf_idx), 32'd0);
        expQ.delete();
        expFrameQ.delete();
        modelIdx = NUM_BUF - 1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        seenBefore = burstsSeen;
        manualDone = 1'b1;
        @(negedge clk);
        manualDone = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("late burst_done ignored busy", 32'(busy), 32'd0);
        checkOutput("late burst_done no burst", 32'(burstsSeen - seenBefore), 32'd0);
        respEn = 1'b1;
        applyStimulus(32'h0000_4000, 32'h0010_0000, 32'h0000_0800, 8, 1);
        waitIdle("frame after reset");

        // Randomized frames with FIFO jitter and dropped starts
        randFifo = 1'b1;
        for (int f = 0; f < 15; f++) begin
            applyStimulus($urandom & 32'hFFFF_FFE0,
                          $urandom & 32'h00FF_FFE0,
                          $urandom & 32'h0000_3FE0,
                          ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 200)),
                          int'($urandom_range(1, 4)));
            waitIdle("random frame");
        end
        randFifo = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
